// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer. Walks a program counter through
//               a combinational instruction memory, issues instructions over
//               a valid/ready handshake, honours branch redirects and stops
//               on a configurable halt encoding. Counts accepted instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [4:0]  RESET_PC  = 5'd0,
    parameter logic [12:0] HALT_WORD = 13'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  imem_addr,
    input  logic [12:0] imem_data,
    output logic [12:0] inst_out,
    output logic [4:0]  inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        branch_valid,
    input  logic [4:0]  branch_target,
    output logic        halted,
    output logic [7:0]  issue_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [7:0] c_COUNT_MAX = 8'hFF;

    state_t      r_state,     w_state_nxt;
    logic [4:0]  r_pc,        w_pc_nxt;
    logic [12:0] r_inst_out,  w_inst_out_nxt;
    logic [4:0]  r_inst_pc,   w_inst_pc_nxt;
    logic        r_inst_valid, w_inst_valid_nxt;
    logic [7:0]  r_count,     w_count_nxt;

    logic        w_accept;
    logic        w_load_slot;

    assign w_accept    = r_inst_valid && inst_ready;
    // A new instruction may be loaded when the output register is empty or draining this cycle.
    assign w_load_slot = !r_inst_valid || inst_ready;

    assign imem_addr   = r_pc;
    assign inst_out    = r_inst_out;
    assign inst_pc     = r_inst_pc;
    assign inst_valid  = r_inst_valid;
    assign halted      = (r_state == S_HALT);
    assign issue_count = r_count;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst_out   <= 13'd0;
            r_inst_pc    <= 5'd0;
            r_inst_valid <= 1'b0;
            r_count      <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst_out   <= w_inst_out_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_count      <= w_count_nxt;
        end
    end

    // Next-state, fetch and issue-count logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_out_nxt   = r_inst_out;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_valid_nxt = r_inst_valid;
        w_count_nxt      = r_count;

        // Accepts always count, including those that coincide with a branch.
        if (w_accept && (r_count != c_COUNT_MAX)) begin
            w_count_nxt = r_count + 8'd1;
        end

        case (r_state)
            S_RUN: begin
                if (branch_valid) begin
                    // Redirect wins: drop any pending instruction, no load this cycle.
                    w_pc_nxt         = branch_target;
                    w_inst_valid_nxt = 1'b0;
                end else if (w_load_slot) begin
                    if (imem_data == HALT_WORD) begin
                        // Halt word is never issued; pc stays pointing at it.
                        w_inst_valid_nxt = 1'b0;
                        w_state_nxt      = S_HALT;
                    end else begin
                        w_inst_out_nxt   = imem_data;
                        w_inst_pc_nxt    = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = r_pc + 5'd1;
                    end
                end
            end
            default: begin
                // IDLE and HALT only respond to start.
                if (start) begin
                    w_pc_nxt         = RESET_PC;
                    w_count_nxt      = 8'd0;
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = S_RUN;
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking testbench for fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  imem_addr;
    logic [12:0] imem_data;
    logic [12:0] inst_out;
    logic [4:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        branch_valid;
    logic [4:0]  branch_target;
    logic        halted;
    logic [7:0]  issue_count;

    logic [12:0] mem [32];

    int n_cmp = 0;
    int n_err = 0;

    assign imem_data = mem[imem_addr];

    fetch_sequencer #(
        .RESET_PC  (5'd0),
        .HALT_WORD (13'h0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halted        (halted),
        .issue_count   (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_basic();
        for (int i = 0; i < 32; i++) mem[i] = 13'h0000;
        mem[0] = 13'h1FFF;
        mem[1] = 13'h04CA;
        mem[2] = 13'h0003;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; inst_ready = 1'b1;
        branch_valid = 1'b0; branch_target = 5'd0;
        mem_basic();
        #12;
        n_cmp++;
        if ({inst_valid, inst_out, inst_pc, halted, issue_count, imem_addr} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_values: got v=%b out=%h pc=%0d halt=%b cnt=%0d addr=%0d, need all 0",
                     inst_valid, inst_out, inst_pc, halted, issue_count, imem_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if ({inst_valid, halted, imem_addr} !== 7'd0) begin
            n_err++;
            $display("FAIL idle_after_reset: got v=%b halt=%b addr=%0d, need 0/0/0", inst_valid, halted, imem_addr);
        end
    endtask

    task automatic test_basic();
        inst_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_latency: valid=%b after start edge, need 0", inst_valid);
        end
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, inst_out} !== {1'b1, 5'd0, 13'h1FFF}) begin
            n_err++; $display("FAIL basic_issue0: got v=%b pc=%0d out=%h, need 1/0/1fff", inst_valid, inst_pc, inst_out);
        end
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, inst_out} !== {1'b1, 5'd1, 13'h04CA}) begin
            n_err++; $display("FAIL basic_issue1: got v=%b pc=%0d out=%h, need 1/1/04ca", inst_valid, inst_pc, inst_out);
        end
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, inst_out} !== {1'b1, 5'd2, 13'h0003}) begin
            n_err++; $display("FAIL basic_issue2: got v=%b pc=%0d out=%h, need 1/2/0003", inst_valid, inst_pc, inst_out);
        end
        tick();
        n_cmp++;
        if ({halted, inst_valid, imem_addr, issue_count} !== {1'b1, 1'b0, 5'd3, 8'd3}) begin
            n_err++; $display("FAIL basic_halt: got halt=%b v=%b addr=%0d cnt=%0d, need 1/0/3/3", halted, inst_valid, imem_addr, issue_count);
        end
    endtask

    task automatic test_stall();
        // Restart from HALT with the consumer stalled.
        inst_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        n_cmp++;
        if ({halted, issue_count, imem_addr} !== {1'b0, 8'd0, 5'd0}) begin
            n_err++; $display("FAIL restart_from_halt: got halt=%b cnt=%0d addr=%0d, need 0/0/0", halted, issue_count, imem_addr);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({inst_valid, inst_pc, inst_out, imem_addr, issue_count} !== {1'b1, 5'd0, 13'h1FFF, 5'd1, 8'd0}) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b pc=%0d out=%h addr=%0d cnt=%0d, need 1/0/1fff/1/0",
                                  i, inst_valid, inst_pc, inst_out, imem_addr, issue_count);
            end
            if (i < 3) tick();
        end
        inst_ready = 1'b1;
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, inst_out} !== {1'b1, 5'd1, 13'h04CA}) begin
            n_err++; $display("FAIL stall_resume1: got v=%b pc=%0d out=%h, need 1/1/04ca", inst_valid, inst_pc, inst_out);
        end
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, inst_out} !== {1'b1, 5'd2, 13'h0003}) begin
            n_err++; $display("FAIL stall_resume2: got v=%b pc=%0d out=%h, need 1/2/0003", inst_valid, inst_pc, inst_out);
        end
        tick();
        n_cmp++;
        if ({halted, issue_count} !== {1'b1, 8'd3}) begin
            n_err++; $display("FAIL stall_halt: got halt=%b cnt=%0d, need 1/3", halted, issue_count);
        end
    endtask

    task automatic test_branch();
        inst_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        inst_ready = 1'b0;
        n_cmp++;
        if ({inst_valid, inst_pc, inst_out, issue_count} !== {1'b1, 5'd1, 13'h04CA, 8'd1}) begin
            n_err++; $display("FAIL branch_setup: got v=%b pc=%0d out=%h cnt=%0d, need 1/1/04ca/1", inst_valid, inst_pc, inst_out, issue_count);
        end
        tick();
        branch_valid = 1'b1; branch_target = 5'd2;
        tick();
        branch_valid = 1'b0; inst_ready = 1'b1;
        n_cmp++;
        if ({inst_valid, imem_addr, issue_count} !== {1'b0, 5'd2, 8'd1}) begin
            n_err++; $display("FAIL branch_drop: got v=%b addr=%0d cnt=%0d, need 0/2/1", inst_valid, imem_addr, issue_count);
        end
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, inst_out} !== {1'b1, 5'd2, 13'h0003}) begin
            n_err++; $display("FAIL branch_target_issue: got v=%b pc=%0d out=%h, need 1/2/0003", inst_valid, inst_pc, inst_out);
        end
        tick();
        n_cmp++;
        if ({halted, issue_count} !== {1'b1, 8'd2}) begin
            n_err++; $display("FAIL branch_halt: got halt=%b cnt=%0d, need 1/2", halted, issue_count);
        end
        // Branch requests in HALT must be ignored.
        branch_valid = 1'b1; branch_target = 5'd5;
        tick(); tick();
        branch_valid = 1'b0;
        n_cmp++;
        if ({halted, imem_addr} !== {1'b1, 5'd3}) begin
            n_err++; $display("FAIL branch_in_halt: got halt=%b addr=%0d, need 1/3", halted, imem_addr);
        end
    endtask

    task automatic test_branch_count();
        inst_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        // Accept of (0,1fff) coincides with the branch and must still count.
        branch_valid = 1'b1; branch_target = 5'd2;
        tick();
        branch_valid = 1'b0;
        n_cmp++;
        if ({inst_valid, imem_addr, issue_count} !== {1'b0, 5'd2, 8'd1}) begin
            n_err++; $display("FAIL branch_accept_count: got v=%b addr=%0d cnt=%0d, need 0/2/1", inst_valid, imem_addr, issue_count);
        end
        tick(); tick();
        n_cmp++;
        if ({halted, issue_count} !== {1'b1, 8'd2}) begin
            n_err++; $display("FAIL branch_count_halt: got halt=%b cnt=%0d, need 1/2", halted, issue_count);
        end
    endtask

    task automatic test_wrap_saturate();
        logic [4:0] exp_pc;
        logic [7:0] exp_cnt;
        for (int i = 0; i < 32; i++) mem[i] = 13'h0AAA;
        inst_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        for (int i = 1; i < 300; i++) begin
            tick();
            start = 1'b0;
            exp_pc  = 5'(i % 32);
            exp_cnt = (i > 255) ? 8'd255 : 8'(i);
            n_cmp++;
            if ({inst_valid, inst_pc, inst_out, issue_count} !== {1'b1, exp_pc, 13'h0AAA, exp_cnt}) begin
                n_err++; $display("FAIL wrap_step[%0d]: got v=%b pc=%0d out=%h cnt=%0d, need 1/%0d/0aaa/%0d",
                                  i, inst_valid, inst_pc, inst_out, issue_count, exp_pc, exp_cnt);
            end
            if (i == 40) start = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        // Still running from the previous test with inst_valid=1.
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({inst_valid, inst_out, inst_pc, halted, issue_count, imem_addr} !== 35'd0) begin
            n_err++; $display("FAIL async_reset: got v=%b out=%h pc=%0d halt=%b cnt=%0d addr=%0d, need all 0",
                              inst_valid, inst_out, inst_pc, halted, issue_count, imem_addr);
        end
        mem_basic();
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick(); start = 1'b0;
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, inst_out, issue_count} !== {1'b1, 5'd0, 13'h1FFF, 8'd0}) begin
            n_err++; $display("FAIL restart_after_reset: got v=%b pc=%0d out=%h cnt=%0d, need 1/0/1fff/0",
                              inst_valid, inst_pc, inst_out, issue_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_branch_count();
        test_wrap_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 5'd0, as the program counter value loaded on reset and on start.
REQ-002 The block SHALL have parameter HALT_WORD, default 13'h0000, as the instruction encoding that stops fetching.
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have a port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have a port start, input, 1 bit: begin fetching from RESET_PC.
REQ-006 The block SHALL have a port imem_addr, output, 5 bits: address to the instruction memory.
REQ-007 The block SHALL have a port imem_data, input, 13 bits: combinational read data for imem_addr.
REQ-008 The block SHALL have a port inst_out, output, 13 bits: issued instruction.
REQ-009 The block SHALL have a port inst_pc, output, 5 bits: address of inst_out.
REQ-010 The block SHALL have a port inst_valid, output, 1 bit: inst_out/inst_pc are valid.
REQ-011 The block SHALL have a port inst_ready, input, 1 bit: the consumer accepts the instruction when inst_valid && inst_ready.
REQ-012 The block SHALL have a port branch_valid, input, 1 bit: redirect request.
REQ-013 The block SHALL have a port branch_target, input, 5 bits: redirect address.
REQ-014 The block SHALL have a port halted, output, 1 bit: high in state HALT.
REQ-015 The block SHALL have a port issue_count, output, 8 bits: number of accepted instructions, saturating.

Function
REQ-016 The block SHALL have states IDLE, RUN and HALT; they SHALL be the only states.
REQ-017 imem_addr SHALL equal pc combinationally in every state.
REQ-018 In IDLE or HALT, start=1 SHALL set pc<=RESET_PC, issue_count<=0, inst_valid<=0 and state<=RUN.
REQ-019 In RUN, start SHALL be ignored.
REQ-020 In RUN, a load slot SHALL exist when inst_valid==0 or inst_ready==1.
REQ-021 In RUN, branch_valid=1 SHALL take priority over the load slot and any accept: pc<=branch_target, inst_valid<=0, with no load that cycle.
REQ-022 A handshake completing in a branch cycle SHALL still count.
REQ-023 In RUN, with no branch and a load slot available, when imem_data != HALT_WORD the block SHALL load inst_out<=imem_data, inst_pc<=pc, inst_valid<=1 and pc<=pc+1, modulo 32 (31 wraps to 0).
REQ-024 In RUN, with no branch and a load slot available, when imem_data == HALT_WORD the block SHALL set inst_valid<=0 and state<=HALT, leave pc unchanged, and never issue the halt word.
REQ-025 With no load slot (inst_valid=1, inst_ready=0), inst_out, inst_pc, inst_valid and pc SHALL hold stable.
REQ-026 Throughput SHALL be one instruction per cycle while inst_ready stays high.
REQ-027 Latency SHALL be: start sampled at edge N, RUN from N, first inst_valid=1 after edge N+1.
REQ-028 issue_count SHALL increment on each cycle with inst_valid && inst_ready, and SHALL saturate at 255.
REQ-029 branch_valid SHALL be ignored in IDLE and HALT.
REQ-030 Entering HALT with an unaccepted instruction is impossible, because the halt check only occurs in a load slot.

Reset
REQ-031 On rst_n=0, asynchronously and at any time including mid-run, the block SHALL set: state=IDLE, pc=RESET_PC, inst_out=0, inst_pc=0, inst_valid=0, halted=0, issue_count=0.
REQ-032 After rst_n deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-033 Memory {0:13'h1FFF, 1:13'h04CA, 2:13'h0003, others 0}, inst_ready=1, start pulse -> issues (0,1FFF), (1,04CA), (2,0003) on consecutive cycles; then halted=1, pc=3, issue_count=3, inst_valid=0.
REQ-034 Same memory, inst_ready=0 for 4 cycles after first valid -> inst_out=1FFF, inst_pc=0 held; after ready=1, the sequence resumes with no skip or duplicate.
REQ-035 branch_valid=1, branch_target=2 while (1,04CA) is pending with ready=0 -> 04CA is dropped, next issue is (2,0003), then halt.
REQ-036 Memory all 13'h0AAA (no halt word), ready=1 -> after pc=31 the next issue is pc=0; issue_count reaches and holds 255.
REQ-037 rst_n pulled low mid-run while inst_valid=1 -> all outputs go to reset values immediately, without waiting for a clock edge; start after release restarts at RESET_PC.
REQ-038 start pulsed while in HALT -> issue_count clears and fetching restarts at RESET_PC; start in RUN -> no effect.
